fb_capture_ctrl: RTL
====================

# fb_capture_ctrl

Single-shot capture controller that sequences the camera pixel stream into the port-A write side of `frame_buffer`: 8-bit data, 15-bit address, `wea`.
- On request, it waits for start-of-frame, writes exactly one H_PIXELS×V_LINES frame at linear addresses 0..H·V−1, then signals completion.
- It checks line and frame structure and stops on malformed input.
- It sits between the camera pixel interface and `frame_buffer`; the display/readout side reads port B independently.

## Interface
Parameters:
- H_PIXELS, 160: pixels per line.
- V_LINES, 120: lines per frame; H_PIXELS·V_LINES ≤ 2^ADDR_W.
- ADDR_W, 15: frame buffer address width.
- DATA_W, 8: pixel width.

Ports:
- clk  in  1  sole clock; also drives `frame_buffer` clka.
- rst_n  in  1  asynchronous, active-low reset.
- cap_req  in  1  start capture; sampled only in IDLE.
- cap_abort  in  1  abandon capture; returns to IDLE from any state.
- cap_busy  out  1  high in ARMED and CAPTURE.
- cap_done  out  1  one-cycle pulse after the last pixel is written.
- cap_err  out  1  sticky error flag; cleared when the next cap_req is accepted.
- pix_valid  in  1  pixel qualifier.
- pix_data  in  DATA_W  pixel value.
- pix_sof  in  1  first pixel of a frame; meaningful only with pix_valid.
- pix_eol  in  1  last pixel of a line; meaningful only with pix_valid.
- fb_wea  out  1  frame buffer write enable.
- fb_addra  out  ADDR_W  write address.
- fb_din  out  DATA_W  write data.

## Operation
States:
- IDLE → ARMED on cap_req.
- ARMED → CAPTURE on pix_valid && pix_sof; that pixel is written at address 0.
- CAPTURE → IDLE when the pixel at address H·V−1 is written; cap_done pulses.
- CAPTURE → IDLE on error or cap_abort.

Counters:
- x in 0..H−1; wraps to 0 on an accepted eol. Width is clog2(H_PIXELS).
- y in 0..V−1; increments on an accepted eol.
- addr is a linear counter in 0..H·V−1, incremented per written pixel. It uses no multiplier.

Write rules:
- An accepted pixel in CAPTURE writes addr with pix_data.
- Pixels in IDLE are ignored: no write.
- Non-sof pixels in ARMED are ignored: no write.
- pix_valid low: no write, and the counters hold.

Errors (set cap_err, no write of the offending pixel, go to IDLE, no cap_done):
- pix_eol ≠ (x == H−1) on a valid pixel in CAPTURE. This covers both short lines and long lines.
- pix_sof on a valid pixel in CAPTURE at an address other than 0. This is a premature frame restart.

Priorities:
- cap_abort beats cap_req. In IDLE with both asserted, stay IDLE and do not clear cap_err.
- cap_abort beats a pixel in the same cycle: no write.
- cap_req is ignored in ARMED and CAPTURE.
- cap_err clears in the same cycle cap_req moves IDLE → ARMED.

Reset behaviour:
- rst_n low forces state IDLE.
- The x, y and addr counters go to 0.
- All outputs go to 0: cap_busy, cap_done, cap_err, fb_wea, fb_addra, fb_din.
- Reset mid-capture discards the partial frame. The frame buffer contents are not cleared.

## Timing
- All outputs are registered.
- Pixel accepted at edge n → fb_wea/fb_addra/fb_din valid after edge n+1, for exactly one cycle per pixel. Latency is 1.
- Sustained throughput is one pixel per clock.
- cap_busy rises the cycle after cap_req is sampled.
- cap_done is asserted in the same cycle as the final fb_wea. cap_busy falls in that same cycle.
- cap_err rises in the cycle after the offending pixel.
- A new cap_req is accepted no earlier than the cycle after cap_done.

## Structure
- Shared package `fb_pkg` holds:
  - FB_ADDR_W = 15 and FB_DATA_W = 8;
  - the default H/V constants;
  - the state enum `cap_state_t` (IDLE, ARMED, CAPTURE).
- One sub-module is natural: `fb_xy_counter`.
  - Contents: x/y/linear-address counters with load-zero, advance and eol inputs.
  - Outputs: x_last, frame_last.
- Everything else is the FSM and the output registers in the top.

## Test plan
Unless a scenario says otherwise, the bench uses H_PIXELS=4 and V_LINES=3.

1. Nominal frame: cap_req, then 12 contiguous pixels 0x10..0x1B with sof on the first and eol on every 4th. Required response:
   - writes at addr 0..11 with data 0x10..0x1B;
   - cap_done on the 12th write;
   - cap_err stays 0.
2. Gapped stream with pre-arm noise:
   - pixels sent before cap_req and non-sof pixels in ARMED produce no fb_wea;
   - random pix_valid gaps produce the same 12 writes, each with latency 1.
3. Short line: eol at x=2 on line 1. Required response:
   - cap_err is 1 on the next cycle;
   - the last write is at addr 5;
   - no cap_done; state is IDLE;
   - the next cap_req clears cap_err.
4. Premature sof at addr 7. Required response:
   - cap_err is set;
   - no write at addr 7;
   - cap_busy is 0.
5. Abort and priority:
   - cap_abort at addr 5 gives no write that cycle and no cap_done;
   - cap_req with cap_abort in IDLE stays IDLE.
6. Reset mid-capture: rst_n low at addr 6. Required response:
   - all outputs 0 asynchronously;
   - a following capture starts at addr 0.
   - Repeat scenario 1 with the defaults 160×120: the final write is at addr 19199.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer capture path: bus widths,
// default frame geometry and the capture controller state encoding.
package fb_pkg;

    localparam int FB_ADDR_W    = 15;
    localparam int FB_DATA_W    = 8;
    localparam int FB_H_PIXELS  = 160;
    localparam int FB_V_LINES   = 120;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

endpackage : fb_pkg

// File: rtl/fb_capture_ctrl_if.sv
// Pixel stream in, frame-buffer port-A write side out. master = the capture
// controller, slave = the camera/frame-buffer environment around it.
interface fb_capture_ctrl_if
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W
);
    // Stream semantics: a pixel exists only in a cycle where pix_valid is high;
    // pix_sof/pix_eol qualify that pixel. There is no back-pressure: the
    // controller consumes every valid pixel in the cycle it is presented.
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              fb_wea;
    logic [ADDR_W-1:0] fb_addra;
    logic [DATA_W-1:0] fb_din;

    modport master (
        input  pix_valid, pix_data, pix_sof, pix_eol,
        output fb_wea, fb_addra, fb_din
    );

    modport slave (
        output pix_valid, pix_data, pix_sof, pix_eol,
        input  fb_wea, fb_addra, fb_din
    );

endinterface : fb_capture_ctrl_if

// File: rtl/fb_xy_counter.sv
// Column/row/linear-address tracker for one frame. The counters always point
// at the position of the next pixel to be written.
module fb_xy_counter
    import fb_pkg::*;
#(
    parameter int H_PIXELS = FB_H_PIXELS,
    parameter int V_LINES  = FB_V_LINES,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_zero,
    input  logic              i_advance,
    input  logic              i_eol,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_x_last,
    output logic              o_frame_last
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_LINES  > 1) ? $clog2(V_LINES)  : 1;

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_addr;

    // Linear address just increments, so no H*y product is ever formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_load_zero) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (i_eol) begin
                r_x <= '0;
                r_y <= r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_x_last     = (r_x == XW'(H_PIXELS - 1));
    assign o_frame_last = o_x_last && (r_y == YW'(V_LINES - 1));

endmodule : fb_xy_counter

// File: rtl/fb_capture_ctrl.sv
// Single-shot frame capture: arms on request, syncs to start-of-frame, writes
// one H x V frame into the frame buffer and aborts on malformed line/frame framing.
module fb_capture_ctrl
    import fb_pkg::*;
#(
    parameter int H_PIXELS = FB_H_PIXELS,
    parameter int V_LINES  = FB_V_LINES,
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap_req,
    input  logic               cap_abort,
    output logic               cap_busy,
    output logic               cap_done,
    output logic               cap_err,
    output cap_state_t         dbg_state,
    fb_capture_ctrl_if.master  bus
);

    cap_state_t        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_din;

    logic [ADDR_W-1:0] w_addr;
    logic              w_x_last;
    logic              w_frame_last;
    logic              w_take;
    logic              w_bad;
    logic              w_write;
    logic              w_load_zero;

    // A pixel belongs to the frame once armed and synced on sof. The sof pixel
    // itself is held to the same eol rule as every other pixel of the frame.
    assign w_take = bus.pix_valid &&
                    ((r_state == CAPTURE) || ((r_state == ARMED) && bus.pix_sof));
    assign w_bad  = w_take && ((bus.pix_eol != w_x_last) ||
                               (bus.pix_sof && (w_addr != '0)));
    assign w_write     = w_take && !w_bad && !cap_abort;
    assign w_load_zero = cap_abort || (r_state == IDLE) ||
                         (w_take && (w_bad || w_frame_last));

    fb_xy_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .ADDR_W   (ADDR_W)
    ) u_xy (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_zero  (w_load_zero),
        .i_advance    (w_write),
        .i_eol        (bus.pix_eol),
        .o_addr       (w_addr),
        .o_x_last     (w_x_last),
        .o_frame_last (w_frame_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_din   <= '0;
        end else begin
            r_wea  <= 1'b0;
            r_done <= 1'b0;
            if (cap_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cap_req) begin
                            r_state <= ARMED;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                        end
                    end
                    ARMED, CAPTURE: begin
                        if (w_bad) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (w_take) begin
                            r_wea   <= 1'b1;
                            r_addra <= w_addr;
                            r_din   <= bus.pix_data;
                            if (w_frame_last) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= CAPTURE;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cap_busy     = r_busy;
    assign cap_done     = r_done;
    assign cap_err      = r_err;
    assign dbg_state    = r_state;
    assign bus.fb_wea   = r_wea;
    assign bus.fb_addra = r_addra;
    assign bus.fb_din   = r_din;

endmodule : fb_capture_ctrl
